jtag_tap_ctrl: RTL and testbench

JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

---
 rtl/jtag_tap_ctrl.sv | 176 +++++++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_ctrl.sv
// Purpose : IEEE 1149.1 TAP controller. Provides the IR, the IDCODE and BYPASS registers, and the scan-chain strobes for the BSR and the ISR.
// Latency : strobes and TDO/TDO_EN are combinational from the registered TAP state and the instruction latch. BYPASS adds one CK of TDI->TDO delay.
// Backpressure: none. The TAP advances one state on every CK rising edge.
//
// Ports:
//   CK, TRST_N          test clock; asynchronous active-low reset to Test-Logic-Reset
//   TMS, TDI            TAP mode select and serial data in, sampled on the CK rising edge
//   TDO_BSR, TDO_ISR    serial returns from the boundary and internal scan chains
//   TDI_BSR, TDI_ISR    TDI forwarded to the two chains
//   clockdr/shiftdr/updatedr_{bs,is}  capture-shift enable, shift select and update strobe per chain
//   bs_en               boundary cells drive from their update latches (EXTEST/INTEST)
//   TDO, TDO_EN         serial data out, and its valid flag (Shift-DR / Shift-IR)
module jtag_tap_ctrl #(
    parameter logic [31:0] IDCODE_VAL = 32'h1923_4001,
    parameter int          IR_W       = 3
) (
    input  logic CK,
    input  logic TRST_N,
    input  logic TMS,
    input  logic TDI,
    input  logic TDO_BSR,
    input  logic TDO_ISR,
    output logic TDI_BSR,
    output logic TDI_ISR,
    output logic clockdr_bs,
    output logic shiftdr_bs,
    output logic updatedr_bs,
    output logic clockdr_is,
    output logic shiftdr_is,
    output logic updatedr_is,
    output logic bs_en,
    output logic TDO,
    output logic TDO_EN
);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
    } tap_state_t;

    localparam logic [IR_W-1:0] IR_CAPTURE  = IR_W'(1);
    localparam logic [IR_W-1:0] INS_EXTEST  = IR_W'(0);
    localparam logic [IR_W-1:0] INS_SAMPLE  = IR_W'(1);
    localparam logic [IR_W-1:0] INS_INTSCAN = IR_W'(2);
    localparam logic [IR_W-1:0] INS_INTEST  = IR_W'(3);
    localparam logic [IR_W-1:0] INS_IDCODE  = IR_W'(4);

    tap_state_t      state, next_state;
    logic [IR_W-1:0] ir_sr;      // IR shift stage
    logic [IR_W-1:0] ir_lat;     // active instruction
    logic            bypass_q;
    logic [31:0]     idcode_q;

    logic sel_bsr, sel_isr, sel_id;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CK or negedge TRST_N) begin
        if (!TRST_N) state <= TLR;
        else         state <= next_state;
    end

    // ------------------------------------------------------------------
    // Next-state logic: standard 1149.1 TMS transitions
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            TLR:      next_state = TMS ? TLR      : RTI;
            RTI:      next_state = TMS ? SEL_DR   : RTI;
            SEL_DR:   next_state = TMS ? SEL_IR   : CAP_DR;
            CAP_DR:   next_state = TMS ? EX1_DR   : SH_DR;
            SH_DR:    next_state = TMS ? EX1_DR   : SH_DR;
            EX1_DR:   next_state = TMS ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: next_state = TMS ? EX2_DR   : PAUSE_DR;
            EX2_DR:   next_state = TMS ? UPD_DR   : SH_DR;
            UPD_DR:   next_state = TMS ? SEL_DR   : RTI;
            SEL_IR:   next_state = TMS ? TLR      : CAP_IR;
            CAP_IR:   next_state = TMS ? EX1_IR   : SH_IR;
            SH_IR:    next_state = TMS ? EX1_IR   : SH_IR;
            EX1_IR:   next_state = TMS ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: next_state = TMS ? EX2_IR   : PAUSE_IR;
            EX2_IR:   next_state = TMS ? UPD_IR   : SH_IR;
            UPD_IR:   next_state = TMS ? SEL_DR   : RTI;
            default:  next_state = TLR;
        endcase
    end

    // ------------------------------------------------------------------
    // Instruction register: shift stage plus the active latch.
    // The latch is reloaded with IDCODE on the edge that enters TLR, so the
    // instruction is already IDCODE in the first TLR cycle. UPD_IR can never
    // be followed by TLR, so the two load conditions never collide.
    // ------------------------------------------------------------------
    always_ff @(posedge CK or negedge TRST_N) begin
        if (!TRST_N) begin
            ir_sr <= IR_CAPTURE;
        end else begin
            case (state)
                CAP_IR:  ir_sr <= IR_CAPTURE;
                SH_IR:   ir_sr <= {TDI, ir_sr[IR_W-1:1]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge CK or negedge TRST_N) begin
        if (!TRST_N)                ir_lat <= INS_IDCODE;
        else if (next_state == TLR) ir_lat <= INS_IDCODE;
        else if (state == UPD_IR)   ir_lat <= ir_sr;
    end

    // Instruction decode. Any code outside the table selects BYPASS.
    always_comb begin
        sel_bsr = (ir_lat == INS_EXTEST) || (ir_lat == INS_SAMPLE) ||
                  (ir_lat == INS_INTEST);
        sel_isr = (ir_lat == INS_INTSCAN);
        sel_id  = (ir_lat == INS_IDCODE);
    end

    // ------------------------------------------------------------------
    // IDCODE and BYPASS data registers. Both hold in the pause states.
    // ------------------------------------------------------------------
    always_ff @(posedge CK or negedge TRST_N) begin
        if (!TRST_N) begin
            bypass_q <= 1'b0;
        end else begin
            case (state)
                CAP_DR:  bypass_q <= 1'b0;
                SH_DR:   bypass_q <= TDI;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CK or negedge TRST_N) begin
        if (!TRST_N) begin
            idcode_q <= IDCODE_VAL;
        end else if (sel_id) begin
            case (state)
                CAP_DR:  idcode_q <= IDCODE_VAL;
                SH_DR:   idcode_q <= {TDI, idcode_q[31:1]};
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode. This logic is combinational from registered state only,
    // so the strobes change once per CK edge. Reset drives them to 0 at once.
    // ------------------------------------------------------------------
    always_comb begin
        TDI_BSR     = TDI;
        TDI_ISR     = TDI;
        clockdr_bs  = sel_bsr && (state == CAP_DR || state == SH_DR);
        shiftdr_bs  = sel_bsr && (state == SH_DR);
        updatedr_bs = sel_bsr && (state == UPD_DR);
        clockdr_is  = sel_isr && (state == CAP_DR || state == SH_DR);
        shiftdr_is  = sel_isr && (state == SH_DR);
        updatedr_is = sel_isr && (state == UPD_DR);
        bs_en       = (ir_lat == INS_EXTEST) || (ir_lat == INS_INTEST);
        TDO_EN      = (state == SH_DR) || (state == SH_IR);
        TDO         = 1'b0;
        if (state == SH_IR) begin
            TDO = ir_sr[0];
        end else if (state == SH_DR) begin
            if (sel_bsr)      TDO = TDO_BSR;
            else if (sel_isr) TDO = TDO_ISR;
            else if (sel_id)  TDO = idcode_q[0];
            else              TDO = bypass_q;
        end
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Purpose : checks jtag_tap_ctrl through its pins. Expected TDO bits go into a queue when the stimulus is driven, and are popped while TDO_EN is high.
// Latency : the bench drives inputs 1 time unit after each CK rising edge, and samples 1 time unit later.
// Backpressure: none.
module tb_jtag_tap_ctrl;

    localparam logic [31:0] IDV = 32'h1923_4001;

    logic CK = 1'b0;
    logic TRST_N = 1'b0;
    logic TMS = 1'b1;
    logic TDI = 1'b0;
    logic TDO_BSR = 1'b0;
    logic TDO_ISR = 1'b0;
    logic TDI_BSR, TDI_ISR;
    logic clockdr_bs, shiftdr_bs, updatedr_bs;
    logic clockdr_is, shiftdr_is, updatedr_is;
    logic bs_en, TDO, TDO_EN;

    jtag_tap_ctrl #(.IDCODE_VAL(IDV), .IR_W(3)) dut (
        .CK(CK), .TRST_N(TRST_N), .TMS(TMS), .TDI(TDI),
        .TDO_BSR(TDO_BSR), .TDO_ISR(TDO_ISR),
        .TDI_BSR(TDI_BSR), .TDI_ISR(TDI_ISR),
        .clockdr_bs(clockdr_bs), .shiftdr_bs(shiftdr_bs), .updatedr_bs(updatedr_bs),
        .clockdr_is(clockdr_is), .shiftdr_is(shiftdr_is), .updatedr_is(updatedr_is),
        .bs_en(bs_en), .TDO(TDO), .TDO_EN(TDO_EN)
    );

    always #5 CK = ~CK;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_q[$];
    int   cnt_cbs, cnt_sbs, cnt_ubs, cnt_cis, cnt_sis, cnt_uis, cnt_en;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clr_cnt();
        cnt_cbs = 0; cnt_sbs = 0; cnt_ubs = 0;
        cnt_cis = 0; cnt_sis = 0; cnt_uis = 0; cnt_en = 0;
    endtask

    function automatic logic [8:0] all_outs();
        return {clockdr_bs, shiftdr_bs, updatedr_bs, clockdr_is, shiftdr_is,
                updatedr_is, bs_en, TDO, TDO_EN};
    endfunction

    // Drives one TAP cycle. The chain returns are TDO_BSR=~tdi and TDO_ISR=tdi.
    // Outputs are observed for the current state, and then the edge is taken.
    task automatic step(input logic tms, input logic tdi);
        TMS = tms; TDI = tdi; TDO_BSR = ~tdi; TDO_ISR = tdi;
        #1;
        cnt_cbs += int'(clockdr_bs); cnt_sbs += int'(shiftdr_bs); cnt_ubs += int'(updatedr_bs);
        cnt_cis += int'(clockdr_is); cnt_sis += int'(shiftdr_is); cnt_uis += int'(updatedr_is);
        cnt_en  += int'(TDO_EN);
        check_eq("tdi_fwd", 32'({TDI_BSR, TDI_ISR}), 32'({tdi, tdi}));
        if (TDO_EN) begin
            if (exp_q.size() == 0) check_eq("tdo_unexpected", 32'(TDO_EN), 32'd0);
            else                   check_eq("tdo", 32'(TDO), 32'(exp_q.pop_front()));
        end else begin
            check_eq("tdo_idle", 32'(TDO), 32'd0);
        end
        @(posedge CK);
        #1;
    endtask

    // From RTI: scan an instruction, and return to RTI. The captured value 001 comes out LSB-first.
    task automatic load_ir(input logic [2:0] code);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(i == 0);
            step(i == 2, code[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check_eq("ir_lat", 32'(dut.ir_lat), 32'(code));
        check_eq("ir_q_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // mode: 0 BSR (~tdi), 1 IDCODE, 2 BYPASS (previous tdi), 3 ISR (tdi)
    task automatic dr_scan(input int n, input logic [127:0] data, input int mode);
        logic prev;
        logic b;
        prev = 1'b0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            b = data[i];
            case (mode)
                0:       exp_q.push_back(~b);
                1:       exp_q.push_back(IDV[i]);
                2:       exp_q.push_back(prev);
                default: exp_q.push_back(b);
            endcase
            prev = b;
            step(i == n - 1, b);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check_eq("dr_q_empty", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic int mode_of(input logic [2:0] c);
        case (c)
            3'd0, 3'd1, 3'd3: return 0;
            3'd2:             return 3;
            3'd4:             return 1;
            default:          return 2;
        endcase
    endfunction

    initial begin
        logic [127:0] d;
        logic         is_bsr, is_isr;
        int           n;

        clr_cnt();
        // Reset
        repeat (2) @(posedge CK);
        #1;
        check_eq("reset_outs", 32'(all_outs()), 32'd0);
        check_eq("reset_ir", 32'(dut.ir_lat), 32'd4);
        TRST_N = 1'b1;

        // One TMS=0 edge goes to RTI. The instruction stays IDCODE, and no strobes are active.
        step(1'b0, 1'b0);
        check_eq("rti_outs", 32'(all_outs()), 32'd0);
        check_eq("rti_ir", 32'(dut.ir_lat), 32'd4);

        // IDCODE comes out LSB-first after reset
        clr_cnt();
        d = {$urandom, $urandom, $urandom, $urandom};
        dr_scan(32, d, 1);
        check_eq("idcode_en_cnt", 32'(cnt_en), 32'd32);
        check_eq("idcode_no_strobes",
                 32'(cnt_cbs + cnt_sbs + cnt_ubs + cnt_cis + cnt_sis + cnt_uis), 32'd0);

        // Every instruction code: the chain selection, the strobe counts and bs_en
        for (int c = 0; c < 8; c++) begin
            load_ir(3'(c));
            is_bsr = (c == 0) || (c == 1) || (c == 3);
            is_isr = (c == 2);
            check_eq("bs_en_pre", 32'(bs_en), 32'((c == 0) || (c == 3)));
            n = (c == 0) ? 72 : 8;
            clr_cnt();
            d = {$urandom, $urandom, $urandom, $urandom};
            dr_scan(n, d, mode_of(3'(c)));
            check_eq("clockdr_bs_cnt", 32'(cnt_cbs), is_bsr ? 32'(n + 1) : 32'd0);
            check_eq("shiftdr_bs_cnt", 32'(cnt_sbs), is_bsr ? 32'(n) : 32'd0);
            check_eq("updatedr_bs_cnt", 32'(cnt_ubs), is_bsr ? 32'd1 : 32'd0);
            check_eq("clockdr_is_cnt", 32'(cnt_cis), is_isr ? 32'(n + 1) : 32'd0);
            check_eq("shiftdr_is_cnt", 32'(cnt_sis), is_isr ? 32'(n) : 32'd0);
            check_eq("updatedr_is_cnt", 32'(cnt_uis), is_isr ? 32'd1 : 32'd0);
            check_eq("tdo_en_cnt", 32'(cnt_en), 32'(n));
            check_eq("bs_en_post", 32'(bs_en), 32'((c == 0) || (c == 3)));
        end

        // BYPASS: with TDI 1,0,1,1 shifted in, TDO is 0,1,0,1
        load_ir(3'b111);
        exp_q.delete();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        exp_q.push_back(1'b0); step(1'b0, 1'b1);
        exp_q.push_back(1'b1); step(1'b0, 1'b0);
        exp_q.push_back(1'b0); step(1'b0, 1'b1);
        exp_q.push_back(1'b1); step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check_eq("bypass_q_empty", 32'(exp_q.size()), 32'd0);

        // PauseDR holds with no strobes. Five TMS=1 edges then reach TLR with the instruction IDCODE.
        load_ir(3'b000);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        clr_cnt();
        repeat (3) step(1'b0, 1'($urandom));
        check_eq("pause_strobes",
                 32'(cnt_cbs + cnt_sbs + cnt_ubs + cnt_cis + cnt_sis + cnt_uis + cnt_en), 32'd0);
        check_eq("pause_bs_en", 32'(bs_en), 32'd1);
        repeat (5) step(1'b1, 1'b0);
        check_eq("tlr_ir", 32'(dut.ir_lat), 32'd4);
        check_eq("tlr_outs", 32'(all_outs()), 32'd0);
        step(1'b0, 1'b0);

        // INTSCAN: TRST_N asserted in mid-scan aborts the scan with no update strobe
        load_ir(3'b010);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(i[0]);
            step(1'b0, i[0]);
        end
        check_eq("pre_abort_shift", 32'(shiftdr_is), 32'd1);
        TRST_N = 1'b0;
        #1;
        check_eq("abort_outs", 32'(all_outs()), 32'd0);
        check_eq("abort_ir", 32'(dut.ir_lat), 32'd4);
        exp_q.delete();
        clr_cnt();
        repeat (3) step(1'b1, 1'b0);
        TRST_N = 1'b1;
        step(1'b0, 1'b0);
        check_eq("abort_no_update", 32'(cnt_uis + cnt_ubs), 32'd0);
        check_eq("abort_strobes", 32'(cnt_cis + cnt_sis + cnt_cbs + cnt_sbs + cnt_en), 32'd0);
        d = {$urandom, $urandom, $urandom, $urandom};
        dr_scan(32, d, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
